uart_tx_sched: RTL and testbench

Scheduler that shares the single UART transmitter between two requesters: the register-file read path (1-byte frames) and the ALU result path (2-byte frames, LSB first). It arbitrates round-robin, captures the winning request, and sequences each byte into the transmitter through the DATA_VALID/BUSY handshake. It sits between the system controller datapaths and the UART TX top, in the same clock domain as the transmitter.

---
 rtl/uart_tx_sched_if.sv | 24 ++
 rtl/uart_tx_sched.sv | 149 ++++++++++++++
 tb/tb_uart_tx_sched.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_sched_if.sv
// Request/transmit bundle for uart_tx_sched. master = scheduler side, slave = requesters plus UART TX.
interface uart_tx_sched_if;
  logic        rf_vld;
  logic [7:0]  rf_data;
  logic        alu_vld;
  logic [15:0] alu_data;
  logic        rf_ack;
  logic        alu_ack;
  logic [7:0]  tx_p_data;
  logic        tx_data_valid;
  logic        tx_busy;
  logic        sched_busy;
  logic        tx_err;

  modport master (
    input  rf_vld, rf_data, alu_vld, alu_data, tx_busy,
    output rf_ack, alu_ack, tx_p_data, tx_data_valid, sched_busy, tx_err
  );

  modport slave (
    output rf_vld, rf_data, alu_vld, alu_data, tx_busy,
    input  rf_ack, alu_ack, tx_p_data, tx_data_valid, sched_busy, tx_err
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin share of one UART TX between RF (1-byte) and ALU (2-byte, LSB first) requests.
// Optional macro SCHED_TIMEOUT_EN: abort a byte with a TX_ERR pulse if TX_BUSY never rises.
module uart_tx_sched #(
  parameter int GAP_CYCLES   = 0,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_sched_if.master bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SEND    = 3'd1;
  localparam logic [2:0] S_WAIT_HI = 3'd2;
  localparam logic [2:0] S_WAIT_LO = 3'd3;
  localparam logic [2:0] S_GAP     = 3'd4;

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  if (BUSY_TIMEOUT < 1) begin : g_bad_timeout
    $error("BUSY_TIMEOUT must be at least 1");
  end

  logic [2:0]    state;
  logic          last_alu;      // 1: ALU won the most recent grant
  logic [15:0]   shadow;
  logic [1:0]    bytes_left;
  logic [GW-1:0] gap_cnt;
  logic          rf_ack_q;
  logic          alu_ack_q;
  logic [7:0]    p_data_q;
  logic          valid_q;
  logic          busy_q;
  logic          err_q;
  logic          grant_alu;
  logic          tmo_hit;

  // On a tie the requester that did not win last time is served.
  assign grant_alu = bus.alu_vld && (!bus.rf_vld || !last_alu);

`ifdef SCHED_TIMEOUT_EN
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;

  assign tmo_hit = ((state == S_SEND) || (state == S_WAIT_HI)) && !bus.tx_busy
                   && (tmo_cnt == TW'(BUSY_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= '0;
    end else if ((state == S_SEND) || (state == S_WAIT_HI)) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end else begin
      tmo_cnt <= '0;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      last_alu   <= 1'b1;
      shadow     <= '0;
      bytes_left <= '0;
      gap_cnt    <= '0;
      rf_ack_q   <= 1'b0;
      alu_ack_q  <= 1'b0;
      p_data_q   <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rf_ack_q  <= 1'b0;
      alu_ack_q <= 1'b0;
      err_q     <= 1'b0;
      if (tmo_hit) begin
        // Abandon the whole frame; last_alu still points at the aborted requester.
        valid_q    <= 1'b0;
        err_q      <= 1'b1;
        bytes_left <= '0;
        busy_q     <= 1'b0;
        state      <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.rf_vld || bus.alu_vld) begin
              shadow     <= grant_alu ? bus.alu_data : {8'h00, bus.rf_data};
              p_data_q   <= grant_alu ? bus.alu_data[7:0] : bus.rf_data;
              bytes_left <= grant_alu ? 2'd2 : 2'd1;
              alu_ack_q  <= grant_alu;
              rf_ack_q   <= !grant_alu;
              last_alu   <= grant_alu;
              valid_q    <= 1'b1;
              busy_q     <= 1'b1;
              state      <= S_SEND;
            end
          end
          S_SEND: begin
            state <= S_WAIT_HI;
          end
          S_WAIT_HI: begin
            if (bus.tx_busy) begin
              valid_q    <= 1'b0;
              shadow     <= shadow >> 8;
              bytes_left <= bytes_left - 2'd1;
              state      <= S_WAIT_LO;
            end
          end
          S_WAIT_LO: begin
            if (!bus.tx_busy) begin
              if (bytes_left != 2'd0) begin
                p_data_q <= shadow[7:0];
                valid_q  <= 1'b1;
                state    <= S_SEND;
              end else if (GAP_CYCLES > 0) begin
                gap_cnt <= '0;
                state   <= S_GAP;
              end else begin
                busy_q <= 1'b0;
                state  <= S_IDLE;
              end
            end
          end
          S_GAP: begin
            if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
              busy_q <= 1'b0;
              state  <= S_IDLE;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.rf_ack        = rf_ack_q;
  assign bus.alu_ack       = alu_ack_q;
  assign bus.tx_p_data     = p_data_q;
  assign bus.tx_data_valid = valid_q;
  assign bus.sched_busy    = busy_q;
  assign bus.tx_err        = err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboarded bench for uart_tx_sched: a behavioural UART TX pops expected bytes as it accepts them.
module tb_uart_tx_sched;
  localparam int TB_GAP   = 4;
  localparam int BUSY_LEN = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tx_busy_m = 1'b0;
  bit   model_en = 1'b1;

  uart_tx_sched_if ifc();
  assign ifc.tx_busy = tx_busy_m;

  uart_tx_sched #(.GAP_CYCLES(TB_GAP), .BUSY_TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  int rf_acks = 0, alu_acks = 0, errs = 0;
  int since_fall = 0, gap_meas = -1, vld_run = 0, last_run = 0, busy_left = 0;
  bit prev_vld = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor plus transmitter model; all sampling on the falling edge.
  always @(negedge clk) begin
    if (ifc.rf_ack) rf_acks++;
    if (ifc.alu_ack) alu_acks++;
    if (ifc.tx_err) errs++;
    if (ifc.tx_data_valid && !prev_vld) gap_meas = since_fall;
    if (ifc.tx_data_valid) vld_run++;
    else begin
      if (vld_run != 0) last_run = vld_run;
      vld_run = 0;
    end
    prev_vld = ifc.tx_data_valid;
    since_fall++;
    if (tx_busy_m) begin
      busy_left--;
      if (busy_left == 0) begin
        tx_busy_m  = 1'b0;
        since_fall = 0;
      end
    end else if (model_en && ifc.tx_data_valid) begin
      if (exp_q.size() == 0) chk("extra_byte", 32'(ifc.tx_p_data), 32'hFFFF_FFFF);
      else chk("tx_byte", 32'(ifc.tx_p_data), 32'(exp_q.pop_front()));
      tx_busy_m = 1'b1;
      busy_left = BUSY_LEN;
    end
  end

  task automatic req(input bit is_alu, input logic [15:0] d, output int lat);
    logic ack;
    @(negedge clk);
    if (is_alu) begin ifc.alu_vld = 1'b1; ifc.alu_data = d; end
    else begin ifc.rf_vld = 1'b1; ifc.rf_data = d[7:0]; end
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      ack = is_alu ? ifc.alu_ack : ifc.rf_ack;
    end while (!ack && lat < 400);
    chk(is_alu ? "alu_ack_seen" : "rf_ack_seen", 32'(ack), 32'd1);
    if (is_alu) ifc.alu_vld = 1'b0; else ifc.rf_vld = 1'b0;
    @(negedge clk);
    chk("ack_pulse_width", 32'(is_alu ? ifc.alu_ack : ifc.rf_ack), 32'd0);
  endtask

  task automatic pair(input logic [7:0] rd, input logic [15:0] ad, input bit alu_first);
    int first = -1;
    if (alu_first) begin
      exp_q.push_back(ad[7:0]); exp_q.push_back(ad[15:8]); exp_q.push_back(rd);
    end else begin
      exp_q.push_back(rd); exp_q.push_back(ad[7:0]); exp_q.push_back(ad[15:8]);
    end
    @(negedge clk);
    ifc.rf_vld = 1'b1; ifc.rf_data = rd;
    ifc.alu_vld = 1'b1; ifc.alu_data = ad;
    for (int i = 0; i < 600 && (ifc.rf_vld || ifc.alu_vld); i++) begin
      @(negedge clk);
      if (ifc.rf_ack) begin ifc.rf_vld = 1'b0; if (first < 0) first = 0; end
      if (ifc.alu_ack) begin ifc.alu_vld = 1'b0; if (first < 0) first = 1; end
    end
    chk("pair_both_acked", 32'(ifc.rf_vld || ifc.alu_vld), 32'd0);
    chk("pair_first_grant", 32'(first), 32'(alu_first));
  endtask

  task automatic wait_idle(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      done = !ifc.sched_busy && !tx_busy_m && (exp_q.size() == 0);
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int a0, e0;
    bit hit;
    ifc.rf_vld = 1'b0; ifc.rf_data = '0;
    ifc.alu_vld = 1'b0; ifc.alu_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({ifc.rf_ack, ifc.alu_ack, ifc.tx_p_data, ifc.tx_data_valid,
                              ifc.sched_busy, ifc.tx_err}), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single RF byte: ACK one cycle after request, frame completes, SCHED_BUSY drops.
    exp_q.push_back(8'hA5);
    req(1'b0, 16'h00A5, lat);
    chk("rf_ack_latency", 32'(lat), 32'd1);
    wait_idle("rf_frame_done");
    chk("rf_ack_count", 32'(rf_acks), 32'd1);

    // ALU result goes out LSB first with one ACK.
    a0 = alu_acks;
    exp_q.push_back(8'h34); exp_q.push_back(8'h12);
    req(1'b1, 16'h1234, lat);
    wait_idle("alu_frame_done");
    chk("alu_ack_once", 32'(alu_acks - a0), 32'd1);

    // Round-robin after reset: RF first, pair again RF first; after a lone RF, ALU first.
    rst = 1'b0; repeat (2) @(negedge clk); rst = 1'b1;
    pair(8'h5A, 16'hBEEF, 1'b0);
    wait_idle("pair1_done");
    pair(8'h66, 16'h7788, 1'b0);
    wait_idle("pair2_done");
    exp_q.push_back(8'h01);
    req(1'b0, 16'h0001, lat);
    wait_idle("lone_rf_done");
    pair(8'h99, 16'hAABB, 1'b1);
    wait_idle("pair3_done");

    // Back-to-back RF frames: GAP cycles plus the IDLE grant cycle between busy fall and next valid.
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    req(1'b0, 16'h0011, lat);
    req(1'b0, 16'h0022, lat);
    wait_idle("gap_frames_done");
    chk("gap_cycles", 32'(gap_meas), 32'(TB_GAP + 1));

    // Reset while waiting for TX_BUSY to fall after byte 0xFE; 0xCA must never appear.
    exp_q.push_back(8'hFE);
    req(1'b1, 16'hCAFE, lat);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      hit = tx_busy_m && !ifc.tx_data_valid;
    end
    chk("reached_wait_lo", 32'(hit), 32'd1);
    rst = 1'b0;
    #1;
    chk("async_reset_outputs", 32'({ifc.rf_ack, ifc.alu_ack, ifc.tx_p_data, ifc.tx_data_valid,
                                    ifc.sched_busy, ifc.tx_err}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("no_frame_after_reset", 32'(ifc.sched_busy), 32'd0);
    exp_q.push_back(8'h3C);
    req(1'b0, 16'h003C, lat);
    wait_idle("post_reset_rf_done");

    // Transmitter never goes busy.
    model_en = 1'b0;
    e0 = errs;
    req(1'b0, 16'h0077, lat);
`ifdef SCHED_TIMEOUT_EN
    for (int i = 0; i < 60 && ifc.tx_data_valid; i++) @(negedge clk);
    chk("tmo_valid_dropped", 32'(ifc.tx_data_valid), 32'd0);
    repeat (2) @(negedge clk);
    chk("tmo_valid_cycles", 32'(last_run), 32'd15);
    chk("tmo_err_pulses", 32'(errs - e0), 32'd1);
    chk("tmo_back_to_idle", 32'(ifc.sched_busy), 32'd0);
    model_en = 1'b1;
`else
    repeat (40) @(negedge clk);
    chk("no_tmo_valid_held", 32'(ifc.tx_data_valid), 32'd1);
    chk("no_tmo_err", 32'(errs - e0), 32'd0);
    exp_q.push_back(8'h77);
    model_en = 1'b1;
    wait_idle("no_tmo_release_done");
`endif

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
